// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: T1..T4 memory-bus sequencer with IR/Z delivery and CB-prefix tracking; optional CPU_BUS_WAIT_EN adds mem_wait stretching in T3.
module cpu_bus_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        bus_op,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
`ifdef CPU_BUS_WAIT_EN
  input  logic              mem_wait,
`endif
  output logic [1:0]        t_state,
  output logic              m_end,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              ir_is_cb,
  output logic              cb_pending,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld
);
  localparam logic [2:0] OP_IDLE = 3'd0, OP_IF = 3'd1, OP_WRITE = 3'd2, OP_READ = 3'd3, OP_IF_CB = 3'd4;
  typedef enum logic [1:0] {T1, T2, T3, T4} t_e;
  t_e                r_t, w_t_n;
  logic [2:0]        r_op, w_op_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd, r_wdata, r_ir, r_rdata;
  logic              r_rd, r_wr, r_m_end, r_ir_valid, r_ir_is_cb, r_cb_pending, r_rdata_vld;
  logic              w_hold, w_cap, w_fetch, w_rd_n, w_wr_n;
  // Outputs are registered one cycle ahead, so everything is derived from the next T-state.
  always_comb begin
`ifdef CPU_BUS_WAIT_EN
    w_hold = (r_t == T3) && mem_wait;
`else
    w_hold = 1'b0;
`endif
    w_t_n   = w_hold ? r_t : t_e'(r_t + 2'd1);
    w_op_n  = (w_t_n == T1) ? bus_op : r_op;
    w_rd_n  = (w_op_n == OP_IF || w_op_n == OP_IF_CB || w_op_n == OP_READ) && (w_t_n != T4);
    w_wr_n  = (w_op_n == OP_WRITE) && (w_t_n == T2 || w_t_n == T3);
    w_cap   = (r_t == T3) && !w_hold;
    w_fetch = (r_op == OP_IF) || (r_op == OP_IF_CB);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t          <= T1;
      r_op         <= OP_IDLE;
      r_addr       <= '0;
      r_wd         <= '0;
      r_wdata      <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_m_end      <= 1'b0;
      r_ir         <= '0;
      r_ir_valid   <= 1'b0;
      r_ir_is_cb   <= 1'b0;
      r_cb_pending <= 1'b0;
      r_rdata      <= '0;
      r_rdata_vld  <= 1'b0;
    end else begin
      r_t         <= w_t_n;
      r_op        <= w_op_n;
      r_rd        <= w_rd_n;
      r_wr        <= w_wr_n;
      r_m_end     <= (w_t_n == T4);
      r_ir_valid  <= w_cap && w_fetch;
      r_rdata_vld <= w_cap && (r_op == OP_READ);
      if (w_t_n == T1) begin
        r_wd <= bus_wdata;
        if (bus_op != OP_IDLE) r_addr <= bus_addr;
      end
      if (w_t_n == T2 && r_op == OP_WRITE) r_wdata <= r_wd;
      if (w_cap && w_fetch) begin
        r_ir         <= mem_rdata;
        r_ir_is_cb   <= (r_op == OP_IF_CB);
        r_cb_pending <= (r_op == OP_IF) && (mem_rdata == DATA_W'(8'hCB));
      end
      if (w_cap && r_op == OP_READ) r_rdata <= mem_rdata;
    end
  end
  assign t_state    = r_t;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_rd     = r_rd;
  assign mem_wr     = r_wr;
  assign m_end      = r_m_end;
  assign ir         = r_ir;
  assign ir_valid   = r_ir_valid;
  assign ir_is_cb   = r_ir_is_cb;
  assign cb_pending = r_cb_pending;
  assign rdata      = r_rdata;
  assign rdata_vld  = r_rdata_vld;
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: directed checks of cpu_bus_ctrl T-state sequencing, strobes, IR/Z delivery and CB tracking.
module tb_cpu_bus_ctrl;
  localparam logic [2:0] IDLE = 3'd0, IF = 3'd1, WR = 3'd2, RD = 3'd3, IFCB = 3'd4;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  bus_op = IDLE;
  logic [15:0] bus_addr = '0, mem_addr;
  logic [7:0]  bus_wdata = '0, mem_wdata, mem_rdata = '0, ir, rdata;
  logic        mem_rd, mem_wr, m_end, ir_valid, ir_is_cb, cb_pending, rdata_vld;
  logic [1:0]  t_state;
`ifdef CPU_BUS_WAIT_EN
  logic        mem_wait = 1'b0;
  int          n;
`endif
  logic [3:0]  s_rd, s_wr, s_iv, s_rv, s_me;
  logic [15:0] s_a1, s_a4;
  logic [7:0]  s_wd2, s_wd4;
  int          checks = 0, failures = 0;

  cpu_bus_ctrl dut (
    .clk(clk), .rst(rst), .bus_op(bus_op), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
`ifdef CPU_BUS_WAIT_EN
    .mem_wait(mem_wait),
`endif
    .t_state(t_state), .m_end(m_end), .ir(ir), .ir_valid(ir_valid), .ir_is_cb(ir_is_cb),
    .cb_pending(cb_pending), .rdata(rdata), .rdata_vld(rdata_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called while in T4; inputs are taken on the edge into T1, then scrambled to prove they are ignored.
  task automatic run_m(input logic [2:0] op, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rd);
    bus_op = op; bus_addr = a; bus_wdata = wd; mem_rdata = rd;
    for (int i = 0; i < 4; i++) begin
      cyc();
      s_rd[i] = mem_rd; s_wr[i] = mem_wr; s_iv[i] = ir_valid; s_rv[i] = rdata_vld; s_me[i] = m_end;
      if (i == 0) s_a1 = mem_addr;
      if (i == 1) s_wd2 = mem_wdata;
      if (i == 3) begin s_a4 = mem_addr; s_wd4 = mem_wdata; end
      if (i == 0) begin bus_op = IDLE; bus_addr = 16'h5A5A; bus_wdata = 8'h00; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(); cyc();
    chk("rst_t", t_state, 0);
    chk("rst_flags", {mem_rd, mem_wr, m_end, ir_valid, rdata_vld, ir_is_cb, cb_pending}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", {ir, rdata, mem_wdata}, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("idle_t%0d", k), t_state, k % 4);
      chk($sformatf("idle_mend%0d", k), m_end, (k % 4) == 3);
      chk($sformatf("idle_strb%0d", k), {mem_rd, mem_wr}, 0);
      if (k < 7) cyc();
    end
    run_m(IF, 16'h0100, 8'h00, 8'h3E);
    chk("if_rd", s_rd, 4'b0111);
    chk("if_wr", s_wr, 4'b0000);
    chk("if_iv", s_iv, 4'b1000);
    chk("if_addr", {s_a1, s_a4}, {16'h0100, 16'h0100});
    chk("if_ir", ir, 8'h3E);
    chk("if_cb", {cb_pending, ir_is_cb}, 2'b00);
    run_m(IF, 16'h0101, 8'h00, 8'hCB);
    chk("pfx_ir", ir, 8'hCB);
    chk("pfx_cb", {cb_pending, ir_is_cb}, 2'b10);
    run_m(IFCB, 16'h0102, 8'h00, 8'h7C);
    chk("cb_ir", ir, 8'h7C);
    chk("cb_flags", {cb_pending, ir_is_cb}, 2'b01);
    chk("cb_iv", s_iv, 4'b1000);
    run_m(WR, 16'hFF80, 8'hA5, 8'h00);
    chk("wr_wr", s_wr, 4'b0110);
    chk("wr_rd", s_rd, 4'b0000);
    chk("wr_wd", {s_wd2, s_wd4}, 16'hA5A5);
    chk("wr_addr", s_a4, 16'hFF80);
    chk("wr_pulses", {s_iv, s_rv}, 0);
    chk("wr_flags", {cb_pending, ir_is_cb}, 2'b01);
    run_m(IDLE, 16'h1234, 8'h00, 8'h00);
    chk("idl_strb", {s_rd, s_wr}, 0);
    chk("idl_addr", s_a4, 16'hFF80);
    chk("idl_mend", s_me, 4'b1000);
    run_m(RD, 16'h0000, 8'h00, 8'h42);
    chk("rd_rd", s_rd, 4'b0111);
    chk("rd_rv", s_rv, 4'b1000);
    chk("rd_addr", s_a1, 16'h0000);
    chk("rd_data", rdata, 8'h42);
    chk("rd_ir", ir, 8'h7C);
    chk("rd_flags", {cb_pending, ir_is_cb}, 2'b01);
    run_m(IF, 16'h0003, 8'h00, 8'hCB);
    chk("err_pfx", {cb_pending, ir_is_cb}, 2'b10);
    run_m(IF, 16'h0004, 8'h00, 8'h00);
    chk("err_if", {cb_pending, ir_is_cb, ir}, {2'b00, 8'h00});
    bus_op = RD; bus_addr = 16'hFFFF; mem_rdata = 8'h77;
    cyc();
    chk("rrst_t1", {mem_rd, mem_addr}, {1'b1, 16'hFFFF});
    bus_op = IDLE;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rrst_t", t_state, 0);
    chk("rrst_strb", {mem_rd, mem_wr, rdata_vld}, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("rrst_nv%0d", k), {rdata_vld, mem_rd}, 0);
    end
    chk("rrst_data", rdata, 8'h00);
`ifdef CPU_BUS_WAIT_EN
    bus_op = RD; bus_addr = 16'h2000; mem_rdata = 8'h11; mem_wait = 1'b0; n = 0;
    cyc(); n++;
    bus_op = IDLE;
    cyc(); n++;
    mem_wait = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(); n++;
      chk($sformatf("wt_hold%0d", k), {t_state, mem_rd}, {2'd2, 1'b1});
    end
    mem_wait = 1'b0; mem_rdata = 8'h99;
    while (m_end !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("wt_len", n, 7);
    chk("wt_data", {rdata, rdata_vld}, {8'h99, 1'b1});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
